ahb_decoder_ctrl: RTL and testbench
===================================

# ahb_decoder_ctrl

AHB-Lite address decoder and data-phase controller for the four-slave response multiplexor. It decodes the address phase into one-hot slave selects. It registers the slave index for the data phase and drives the mux `sel`. It implements a built-in default slave that returns a two-cycle ERROR for accesses outside the four mapped regions, and produces the final bus `hready`/`hresp` seen by the master and all slaves.

## Interface
- `S1_REGION`, 4'h0, value of `haddr[31:28]` selecting slave 1
- `S2_REGION`, 4'h1, region for slave 2
- `S3_REGION`, 4'h2, region for slave 3
- `S4_REGION`, 4'h3, region for slave 4
- `hclk` in 1: bus clock, all state on rising edge
- `hresetn` in 1: asynchronous, active-low reset
- `haddr` in 32: master address-phase address
- `htrans` in 2: master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
- `hreadyout_mux` in 1: `hreadyout` from the response multiplexor
- `hresp_mux` in 1: `hresp` from the response multiplexor
- `hsel_1`..`hsel_4` out 1 each: combinational address-phase slave selects
- `sel` out 2: registered data-phase index to the multiplexor
- `hready` out 1: final bus ready, to the master and all slave `hready` inputs
- `hresp` out 1: final bus response, 0=OKAY, 1=ERROR
- `err_cnt` out 8: saturating count of default-slave ERROR responses

## Operation
- **Decode.** `haddr[31:28]` is compared to `S1..S4_REGION`. A match asserts exactly one `hsel_n`. No match means unmapped, and all `hsel_n` are 0.
  - Region values are distinct, so at most one matches.
  - `hsel_n` does not depend on `htrans`.
- **Address-phase sample.** This happens on any edge where `hready`=1. The following are captured:
  - `sel_q` gets the decoded index (0..3). It holds its previous value when unmapped.
  - `def_q` gets the unmapped flag.
  - `act_q` is set when `htrans` is NONSEQ or SEQ.
  - When `hready`=0, all three hold.
- `sel` = `sel_q`.
- **Response path when `def_q`=0.** `hready` = `hreadyout_mux` and `hresp` = `hresp_mux`.
- **Default slave FSM** (used when `def_q`=1), states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: if `def_q`=1 and `act_q`=1, go to DS_ERR1. Otherwise the default-slave response is OKAY with zero wait (`hready`=1, `hresp`=0).
  - DS_ERR1: drives `hready`=0, `hresp`=1. Unconditionally goes to DS_ERR2.
  - DS_ERR2: drives `hready`=1, `hresp`=1, and increments `err_cnt`, saturating at 8'hFF. Goes to DS_ERR1 if the newly sampled address is unmapped and active, otherwise to DS_IDLE.
  - The entry transition is evaluated on the registered data-phase flags, so the error sequence starts in the cycle after the address phase. DS_ERR1 is the first data-phase cycle.
- The FSM and the data-phase registers are implemented so that the first data-phase cycle of an unmapped active transfer already shows `hready`=0, `hresp`=1. The FSM state is next-state-decoded at the same sampling edge that sets `def_q`.

## Timing
- **Reset values:**
  - `sel`=0, `def_q`=0, `act_q`=0, state DS_IDLE
  - `hready`=1 (via the mux path; `hreadyout_mux` is assumed 1 from slaves in reset), `hresp`=0
  - `err_cnt`=0, `hsel_n` follow `haddr`
- **Decode latency:** `hsel_n` is combinational, 0 cycles. `sel` updates 1 cycle after the sampled address phase.
- **Slave wait states:** `hreadyout_mux`=0 freezes `sel_q`, `def_q` and `act_q` for as long as it is low.
- **ERROR response:** always exactly 2 cycles, (0,1) then (1,1). `htrans` changes during DS_ERR1 are ignored because `hready`=0.
- **Back-to-back unmapped NONSEQ/SEQ:** DS_ERR1, DS_ERR2, DS_ERR1, DS_ERR2 with no idle cycle between them.
- **Mapped transfer after ERROR:** the address sampled in DS_ERR2 is served by the mux path in the next cycle.
- **Unmapped IDLE/BUSY:** OKAY with zero wait. `err_cnt` is unchanged.
- **Reset mid-ERROR:** `hresetn` low immediately forces DS_IDLE, `hready`=1, `hresp`=0, `err_cnt`=0.

## Structure
- A shared package `ahb_pkg` holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
  - HRESP encodings (OKAY, ERROR)
  - the `ds_state_t` enum
  - the default region constants
- One natural sub-module, `ahb_default_slave`, contains the FSM, the two-cycle ERROR sequence and `err_cnt`. The decoder, the data-phase registers and the response-select logic stay in the top level.

## Test plan
- **Reset:** assert `hresetn`=0 mid-run, release → `sel`=0, `hready`=1, `hresp`=0, `err_cnt`=0.
- **Mapped decode:** `haddr`=0x2000_0010, NONSEQ, slaves ready → `hsel_3`=1 in the same cycle, `sel`=2 next cycle. `hready`/`hresp` track slave 3.
- **Slave wait:** NONSEQ to 0x1000_0000, slave 2 holds `hreadyout`=0 for 3 cycles, and the next address is 0x3000_0000 → `sel` stays 1 for all 3 wait cycles and becomes 3 only after slave 2 is ready.
- **Unmapped NONSEQ:** `haddr`=0x8000_0000 → all `hsel_n`=0. Next cycle (`hready`,`hresp`)=(0,1), then (1,1). `err_cnt`=1.
- **Back-to-back errors:** two unmapped SEQ transfers followed by a mapped one to 0x0000_0004 → the pattern (0,1),(1,1),(0,1),(1,1), then OKAY from slave 1. `err_cnt`=2.
- **Unmapped IDLE and saturation:** IDLE to 0xF000_0000 → OKAY, `err_cnt` unchanged. Then 300 unmapped NONSEQ → `err_cnt`=0xFF. Reset in DS_ERR1 → immediate `hready`=1.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, default-slave state type and default slave regions.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [3:0] DEF_S1_REGION = 4'h0;
  localparam logic [3:0] DEF_S2_REGION = 4'h1;
  localparam logic [3:0] DEF_S3_REGION = 4'h2;
  localparam logic [3:0] DEF_S4_REGION = 4'h3;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped active transfers, with saturating error count.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready_i,
  input  logic       start_i,
  output logic       hready_o,
  output logic       hresp_o,
  output logic [7:0] err_cnt_o
);
  ds_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  // Next state is decoded from the address phase being sampled so ERR1 lines up with the first data-phase cycle.
  always_comb begin
    state_d = state_q == DS_ERR1 ? DS_ERR2 : hready_i ? (start_i ? DS_ERR1 : DS_IDLE) : state_q;
    cnt_d   = (state_q == DS_ERR2 && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign hready_o  = state_q != DS_ERR1;
  assign hresp_o   = state_q == DS_IDLE ? HRESP_OKAY : HRESP_ERROR;
  assign err_cnt_o = cnt_q;
endmodule

// File: rtl/ahb_decoder_ctrl.sv
// ahb_decoder_ctrl: AHB-Lite address decoder, data-phase select register and final hready/hresp mux.
module ahb_decoder_ctrl
  import ahb_pkg::*;
#(
  parameter logic [3:0] S1_REGION = DEF_S1_REGION,
  parameter logic [3:0] S2_REGION = DEF_S2_REGION,
  parameter logic [3:0] S3_REGION = DEF_S3_REGION,
  parameter logic [3:0] S4_REGION = DEF_S4_REGION
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hreadyout_mux,
  input  logic        hresp_mux,
  output logic        hsel_1,
  output logic        hsel_2,
  output logic        hsel_3,
  output logic        hsel_4,
  output logic [1:0]  sel,
  output logic        hready,
  output logic        hresp,
  output logic [7:0]  err_cnt
);
  logic [3:0] region;
  logic [1:0] idx;
  logic       mapped, active, unused;
  logic [1:0] sel_q, sel_d;
  logic       def_q, def_d, act_q, act_d;
  logic       ds_hready, ds_hresp;
  assign region = haddr[31:28];
  assign unused = ^haddr[27:0];
  always_comb begin
    hsel_1 = region == S1_REGION;
    hsel_2 = region == S2_REGION;
    hsel_3 = region == S3_REGION;
    hsel_4 = region == S4_REGION;
    mapped = hsel_1 | hsel_2 | hsel_3 | hsel_4;
    idx    = hsel_2 ? 2'd1 : hsel_3 ? 2'd2 : hsel_4 ? 2'd3 : 2'd0;
    active = htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ;
  end
  // Unmapped phases keep the last slave index so the mux never glitches to a stale slave.
  always_comb begin
    sel_d = (hready && mapped) ? idx : sel_q;
    def_d = hready ? !mapped : def_q;
    act_d = hready ? active : act_q;
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sel_q <= '0;
      def_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      def_q <= def_d;
      act_q <= act_d;
    end
  end
  ahb_default_slave u_ds (
    .clk       (hclk),
    .rst_n     (hresetn),
    .hready_i  (hready),
    .start_i   (!mapped && active),
    .hready_o  (ds_hready),
    .hresp_o   (ds_hresp),
    .err_cnt_o (err_cnt)
  );
  assign sel    = sel_q;
  assign hready = def_q ? ds_hready : hreadyout_mux;
  assign hresp  = def_q ? ds_hresp : hresp_mux;
endmodule

// File: tb/tb_ahb_decoder_ctrl.sv
// tb_ahb_decoder_ctrl: directed and randomized checks against a transfer-level reference model.
module tb_ahb_decoder_ctrl;
  import ahb_pkg::*;
  logic        hclk = 1'b0, hresetn = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hreadyout_mux = 1'b1, hresp_mux = 1'b0;
  logic        hsel_1, hsel_2, hsel_3, hsel_4, hready, hresp;
  logic [1:0]  sel;
  logic [7:0]  err_cnt;
  logic [3:0]  hsel;
  int tests = 0, fails = 0;
  logic [1:0] m_sel;
  logic       m_def, m_act, m_phase;
  int         m_cnt;
  logic [3:0] e_hsel;
  logic       e_hready, e_hresp;

  ahb_decoder_ctrl dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hreadyout_mux(hreadyout_mux), .hresp_mux(hresp_mux),
    .hsel_1(hsel_1), .hsel_2(hsel_2), .hsel_3(hsel_3), .hsel_4(hsel_4),
    .sel(sel), .hready(hready), .hresp(hresp), .err_cnt(err_cnt)
  );

  always #5 hclk = ~hclk;
  assign hsel = {hsel_4, hsel_3, hsel_2, hsel_1};

  task automatic model_reset;
    m_sel = 2'd0; m_def = 1'b0; m_act = 1'b0; m_phase = 1'b0; m_cnt = 0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r, input logic p);
    int rg;
    haddr = a; htrans = t; hreadyout_mux = r; hresp_mux = p;
    #1;
    rg = int'(a[31:28]);
    e_hsel = rg < 4 ? 4'(1 << rg) : 4'd0;
    if (m_def && m_act) begin e_hready = m_phase; e_hresp = 1'b1; end
    else if (m_def) begin e_hready = 1'b1; e_hresp = 1'b0; end
    else begin e_hready = r; e_hresp = p; end
  endtask

  task automatic tick;
    int rg;
    rg = int'(haddr[31:28]);
    if (m_def && m_act && m_phase) m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
    if (m_def && m_act && !m_phase) m_phase = 1'b1;
    else if (e_hready) begin
      m_def = rg >= 4;
      if (rg < 4) m_sel = 2'(rg);
      m_act = htrans[1];
      m_phase = 1'b0;
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset;
    hresetn = 1'b0;
    model_reset();
    drive(32'h4000_0000, HTRANS_NONSEQ, 1'b1, 1'b0);
    tests++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel got %0d exp 0", sel); end
    tests++; if ({hready, hresp} !== 2'b10) begin fails++; $display("FAIL reset_resp got %b exp 10", {hready, hresp}); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", err_cnt); end
    @(posedge hclk); #1;
    hresetn = 1'b1;
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp, sel} !== 4'b1000) begin fails++; $display("FAIL reset_release got %b exp 1000", {hready, hresp, sel}); end
    tick();
  endtask

  task automatic test_mapped_decode;
    drive(32'h2000_0010, HTRANS_NONSEQ, 1'b1, 1'b0);
    tests++; if (hsel !== 4'b0100) begin fails++; $display("FAIL decode_hsel got %b exp 0100", hsel); end
    tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b0, 1'b1);
    tests++; if (sel !== 2'd2) begin fails++; $display("FAIL decode_sel got %0d exp 2", sel); end
    tests++; if ({hready, hresp} !== 2'b01) begin fails++; $display("FAIL decode_track_wait got %b exp 01", {hready, hresp}); end
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b10) begin fails++; $display("FAIL decode_track_ok got %b exp 10", {hready, hresp}); end
    tick();
  endtask

  task automatic test_slave_wait;
    drive(32'h1000_0000, HTRANS_NONSEQ, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h3000_0000, HTRANS_NONSEQ, 1'b0, 1'b0);
      tests++; if (sel !== 2'd1 || hready !== 1'b0) begin fails++; $display("FAIL wait_hold%0d got sel=%0d hready=%b exp sel=1 hready=0", i, sel, hready); end
      tick();
    end
    drive(32'h3000_0000, HTRANS_NONSEQ, 1'b1, 1'b0);
    tests++; if (sel !== 2'd1) begin fails++; $display("FAIL wait_last got %0d exp 1", sel); end
    tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if (sel !== 2'd3) begin fails++; $display("FAIL wait_next got %0d exp 3", sel); end
    tick();
  endtask

  task automatic test_unmapped;
    int c0;
    c0 = m_cnt;
    drive(32'h8000_0000, HTRANS_NONSEQ, 1'b1, 1'b0);
    tests++; if (hsel !== 4'b0000) begin fails++; $display("FAIL unmapped_hsel got %b exp 0000", hsel); end
    tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b01) begin fails++; $display("FAIL unmapped_err1 got %b exp 01", {hready, hresp}); end
    tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b11) begin fails++; $display("FAIL unmapped_err2 got %b exp 11", {hready, hresp}); end
    tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b10) begin fails++; $display("FAIL unmapped_after got %b exp 10", {hready, hresp}); end
    tests++; if (err_cnt !== 8'(c0 + 1)) begin fails++; $display("FAIL unmapped_cnt got %0d exp %0d", err_cnt, c0 + 1); end
    tick();
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = m_cnt;
    drive(32'h8000_0000, HTRANS_SEQ, 1'b1, 1'b0);
    tick();
    drive(32'h9000_0000, 2'($urandom), 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b01) begin fails++; $display("FAIL b2b_err1a got %b exp 01", {hready, hresp}); end
    tick();
    drive(32'hA000_0000, HTRANS_SEQ, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b11) begin fails++; $display("FAIL b2b_err2a got %b exp 11", {hready, hresp}); end
    tick();
    drive(32'h0000_0004, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b01) begin fails++; $display("FAIL b2b_err1b got %b exp 01", {hready, hresp}); end
    tick();
    drive(32'h0000_0004, HTRANS_NONSEQ, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b11) begin fails++; $display("FAIL b2b_err2b got %b exp 11", {hready, hresp}); end
    tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp, sel} !== 4'b1000) begin fails++; $display("FAIL b2b_mapped got %b exp 1000", {hready, hresp, sel}); end
    tests++; if (err_cnt !== 8'(c0 + 2)) begin fails++; $display("FAIL b2b_cnt got %0d exp %0d", err_cnt, c0 + 2); end
    tick();
  endtask

  task automatic test_idle_saturate;
    int c0;
    c0 = m_cnt;
    drive(32'hF000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if (hsel !== 4'b0000 || {hready, hresp} !== 2'b10) begin fails++; $display("FAIL idle_unmapped got hsel=%b resp=%b exp 0000 10", hsel, {hready, hresp}); end
    tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b10 || err_cnt !== 8'(c0)) begin fails++; $display("FAIL idle_okay got resp=%b cnt=%0d exp 10 %0d", {hready, hresp}, err_cnt, c0); end
    tick();
    for (int i = 0; i < 600; i++) begin
      drive({4'($urandom_range(4, 15)), 28'($urandom)}, HTRANS_NONSEQ, 1'b1, 1'b0);
      tick();
    end
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0); tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0); tick();
    tests++; if (err_cnt !== 8'hFF) begin fails++; $display("FAIL saturate got %0d exp 255", err_cnt); end
    drive(32'h8000_0000, HTRANS_NONSEQ, 1'b1, 1'b0);
    tick();
    drive(32'h0000_0000, HTRANS_IDLE, 1'b1, 1'b0);
    tests++; if ({hready, hresp} !== 2'b01) begin fails++; $display("FAIL pre_reset_err1 got %b exp 01", {hready, hresp}); end
    hresetn = 1'b0;
    #1;
    tests++; if ({hready, hresp} !== 2'b10 || err_cnt !== 8'd0 || sel !== 2'd0) begin fails++; $display("FAIL reset_mid_err got resp=%b cnt=%0d sel=%0d exp 10 0 0", {hready, hresp}, err_cnt, sel); end
    model_reset();
    @(posedge hclk); #1;
    hresetn = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = {($urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15))), 28'($urandom)};
      drive(a, 2'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
      tests++; if (hsel !== e_hsel) begin fails++; $display("FAIL rnd_hsel[%0d] got %b exp %b", i, hsel, e_hsel); end
      tests++; if (sel !== m_sel) begin fails++; $display("FAIL rnd_sel[%0d] got %0d exp %0d", i, sel, m_sel); end
      tests++; if (hready !== e_hready) begin fails++; $display("FAIL rnd_hready[%0d] got %b exp %b", i, hready, e_hready); end
      tests++; if (hresp !== e_hresp) begin fails++; $display("FAIL rnd_hresp[%0d] got %b exp %b", i, hresp, e_hresp); end
      tests++; if (err_cnt !== 8'(m_cnt)) begin fails++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, err_cnt, m_cnt); end
      tick();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge hclk);
    #1;
    test_reset();
    test_mapped_decode();
    test_slave_wait();
    test_unmapped();
    test_back_to_back();
    test_random();
    test_idle_saturate();
    test_random();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
